imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Byte-stream program loader that writes into the multicycle CPU's instruction memory.
//   It receives a framed image of assembler output, assembles big-endian 32-bit words and writes them from word 0 up.
//   It holds the CPU in reset (cpu_rst high) until the frame passes its checksum.
//   It then presents the start PC on outside_pc and releases the CPU.
//   It sits between the host/UART byte source and Main (instruction memory + RST/outside_pc).
// PARAMETERS
//   ADDR_W      8       instruction-memory word-address width; capacity 2**ADDR_W words
//   DEFAULT_PC  32'h0   outside_pc value after reset and until a frame supplies one
// PORTS
//   CLK         in   1       clock, all logic on rising edge
//   RST         in   1       reset, synchronous, active-low
//   byte_valid  in   1       byte_data valid this cycle
//   byte_data   in   8       incoming stream byte
//   byte_ready  out  1       loader accepts a byte when byte_valid && byte_ready
//   mem_we      out  1       instruction-memory write strobe, one-cycle pulse
//   mem_addr    out  ADDR_W  word address of the current write
//   mem_wdata   out  32      word written
//   cpu_rst     out  1       active-high reset to CPU (drives Main.RST)
//   outside_pc  out  32      start PC to CPU (drives Main.outside_pc)
//   loading     out  1       frame in progress (states PC..CHK)
//   done        out  1       frame accepted, CPU running
//   err         out  1       frame rejected
// BEHAVIOUR
//   Reset (RST=0 at a clock edge), takes effect at any time including mid-frame:
//     state=IDLE; byte_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_rst=1.
//     outside_pc=DEFAULT_PC; loading=0; done=0; err=0; checksum=0.
//   Frame format: 0xA5, PC[31:24..7:0], N[15:8], N[7:0], N words x 4 bytes (MSB first), CHK.
//     CHK = XOR of every byte after 0xA5 up to, but excluding, CHK.
//   States and transitions; every transition is taken on an accepted byte:
//     IDLE: 0xA5 -> PC, clears checksum and mem_addr; any other byte is discarded and the state stays IDLE.
//     PC:   4 bytes shift into a PC shadow register. outside_pc does NOT change yet. Then -> CNT.
//     CNT:  2 bytes form N. N==0 -> CHK. N > 2**ADDR_W -> ERR. Otherwise -> DATA.
//     DATA: on the 4th byte of each word, mem_wdata = assembled word and mem_we = 1 for exactly the next cycle at mem_addr.
//           mem_addr increments the cycle after the pulse.
//           The last word's pulse issues, then -> CHK. byte_ready stays 1, so back-to-back bytes are allowed.
//     CHK:  byte == running XOR -> RUN, and outside_pc <= PC shadow. Mismatch -> ERR.
//     RUN:  cpu_rst=0, done=1, byte_ready=0. Exit only via RST.
//     ERR:  cpu_rst=1, err=1, byte_ready=0. Memory contents are undefined. Exit only via RST.
//   cpu_rst falls in the same cycle done rises (registered, one cycle after the CHK byte is accepted).
//   cpu_rst is high in every state except RUN, so the CPU never sees a partial image.
//   Latency: a word's write strobe comes 1 cycle after its 4th byte. RUN is entered 1 cycle after the CHK byte.
//   Bytes with byte_valid=0 are ignored in all states; gaps of any length are allowed between bytes.
//   N == 2**ADDR_W: the final mem_addr wraps to 0 after the last write. This is legal and no extra write occurs.
// TESTING
//   1) A5 00000004 0002 24010005 24020007 CHK=XOR -> writes: addr0=24010005, addr1=24020007.
//      Then done=1, cpu_rst=0, outside_pc=4.
//   2) Leading 3C,FF before A5 + valid frame -> the junk bytes are discarded; result identical to case 1.
//   3) Case 1 with a corrupted CHK -> err=1, cpu_rst stays 1, outside_pc stays DEFAULT_PC, byte_ready=0.
//   4) N=0x0101 with ADDR_W=8 -> ERR after the 2nd N byte, no mem_we pulses.
//      N=0 with a correct CHK -> RUN, no writes.
//   5) RST=0 asserted after the 2nd data byte, then released -> IDLE, mem_addr=0, cpu_rst=1.
//      A new full frame then loads correctly.
//   6) byte_valid toggled randomly during case 1 -> identical memory writes and final outputs.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the CPU instruction memory
// Holds the CPU in reset until a checksummed image is written, then releases it at the frame's PC.
module imem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] DEFAULT_PC = 32'h0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic [31:0]       outside_pc,
  output logic              loading,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {S_IDLE, S_PC, S_CNT, S_DATA, S_CHK, S_RUN, S_ERR} state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         pc_shadow_q, pc_shadow_d;
  logic [15:0]         words_q, words_d;
  logic [7:0]          chk_q, chk_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         outside_pc_q, outside_pc_d;

  logic                acc;
  logic [31:0]         shifted;
  logic [15:0]         n_full;

  assign acc     = byte_valid && byte_ready;
  assign shifted = {shift_q[23:0], byte_data};
  assign n_full  = {shift_q[7:0], byte_data};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 32'd0;
      pc_shadow_q  <= 32'd0;
      words_q      <= 16'd0;
      chk_q        <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      outside_pc_q <= DEFAULT_PC;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      pc_shadow_q  <= pc_shadow_d;
      words_q      <= words_d;
      chk_q        <= chk_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      outside_pc_q <= outside_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc) begin
      case (state_q)
        S_IDLE: if (byte_data == 8'hA5) state_d = S_PC;
        S_PC:   if (byte_cnt_q == 2'd3) state_d = S_CNT;
        S_CNT: begin
          if (byte_cnt_q == 2'd1) begin
            if (n_full == 16'd0)                state_d = S_CHK;
            else if ({1'b0, n_full} > CAPACITY) state_d = S_ERR;
            else                                state_d = S_DATA;
          end
        end
        S_DATA: if (byte_cnt_q == 2'd3 && words_q == 16'd1) state_d = S_CHK;
        S_CHK:  state_d = (byte_data == chk_q) ? S_RUN : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    pc_shadow_d  = pc_shadow_q;
    words_d      = words_q;
    chk_d        = chk_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_we_q ? mem_addr_q + ADDR_W'(1) : mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    outside_pc_d = outside_pc_q;
    if (acc) begin
      case (state_q)
        S_IDLE: begin
          if (byte_data == 8'hA5) begin
            chk_d      = 8'd0;
            mem_addr_d = '0;
            byte_cnt_d = 2'd0;
          end
        end
        S_PC, S_CNT, S_DATA: begin
          chk_d      = chk_q ^ byte_data;
          shift_d    = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_PC && byte_cnt_q == 2'd3) pc_shadow_d = shifted;
          if (state_q == S_CNT && byte_cnt_q == 2'd1) begin
            words_d    = n_full;
            byte_cnt_d = 2'd0;
          end
          if (state_q == S_DATA && byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = shifted;
            words_d     = words_q - 16'd1;
          end
        end
        S_CHK: if (byte_data == chk_q) outside_pc_d = pc_shadow_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_ready = (state_q != S_RUN) && (state_q != S_ERR);
    cpu_rst    = (state_q != S_RUN);
    done       = (state_q == S_RUN);
    err        = (state_q == S_ERR);
    loading    = (state_q == S_PC) || (state_q == S_CNT) || (state_q == S_DATA) || (state_q == S_CHK);
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign outside_pc = outside_pc_q;
endmodule
